demorgan_sweep: RTL and testbench
=================================

DEMORGAN_SWEEP -- requirements
Module: demorgan_sweep

Interface
REQ-001 SHALL have parameter WIDTH, default 2, operand width in bits; legal range 1..8.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports are clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request an exhaustive sweep; sampled only in IDLE.
REQ-006 busy  output  1  high in SWEEP and DRAIN.
REQ-007 done  output  1  one-cycle pulse marking sweep completion.
REQ-008 a, b  output  WIDTH each  currently applied stimulus operands.
REQ-009 nAandB, nAorB  output  WIDTH each  registered ~(a&b) and ~(a|b) for the previous vector.
REQ-010 nAornB, nAandnB  output  WIDTH each  registered (~a)|(~b) and (~a)&(~b) for the previous vector.
REQ-011 mismatch_count  output  2*WIDTH+1  number of failing vectors in the current/last sweep.
REQ-012 fail_valid  output  1  high once a failing vector has been captured.
REQ-013 fail_a, fail_b  output  WIDTH each  operands of the first failing vector.

Function
REQ-014 SHALL implement states IDLE, SWEEP, DRAIN, DONE.
REQ-015 IDLE -> SWEEP on an edge with start=1; that edge clears index, mismatch_count, fail_valid, fail_a, fail_b.
REQ-016 In SWEEP, index (2*WIDTH bits) increments once per cycle; a=index[2*WIDTH-1:WIDTH], b=index[WIDTH-1:0].
REQ-017 SWEEP -> DRAIN on the edge after index = 2^(2*WIDTH)-1; no wrap-around is applied.
REQ-018 Stage 1: each cycle the four law outputs register the values for the current a,b (latency 1 cycle).
REQ-019 Stage 2: a vector fails if nAornB != nAandB or nAandnB != nAorB on any bit; comparison uses the stage-1 registers and their captured operands.
REQ-020 On a failing vector, mismatch_count increments by 1; it cannot overflow (max 2^(2*WIDTH)).
REQ-021 On the first failing vector of a sweep, fail_a/fail_b capture its operands and fail_valid sets; later failures leave them unchanged.
REQ-022 DRAIN lasts one cycle so the last vector is compared; DRAIN -> DONE.
REQ-023 DONE lasts one cycle with done=1; DONE -> IDLE.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 With start held high, a new sweep begins on the first IDLE edge after DONE.
REQ-026 Results (mismatch_count, fail_*) SHALL hold in IDLE until the next accepted start.
REQ-027 a, b SHALL hold the last vector in DRAIN, DONE and IDLE.
REQ-028 From start edge k: SWEEP spans 2^(2*WIDTH) cycles, then DRAIN, then done=1 in cycle 2^(2*WIDTH)+2 after k.

Reset
REQ-029 reset=1 at any edge, including mid-sweep, SHALL force IDLE and set every output to 0.
REQ-030 reset SHALL take priority over start.

Configuration
REQ-031 Macro DEMORGAN_FAULT_INJECT_EN, when defined, SHALL add input fault_mask (WIDTH), XORed into nAornB before registration.
REQ-032 Without DEMORGAN_FAULT_INJECT_EN, the fault_mask port SHALL not exist and nAornB is fault-free.

Verification
REQ-033 WIDTH=2, reset then start pulse -> done exactly 18 cycles after start edge, mismatch_count=0, fail_valid=0.
REQ-034 WIDTH=2, fault_mask=2'b01 -> mismatch_count=16, fail_valid=1, fail_a=0, fail_b=0.
REQ-035 WIDTH=1, index 2 (a=1,b=0) -> nAandB=1, nAorB=0, nAornB=1, nAandnB=0 one cycle later.
REQ-036 WIDTH=2, reset asserted at sweep cycle 5 -> next cycle IDLE, busy=0, all outputs 0; new start then gives full 18-cycle sweep.
REQ-037 start pulsed during SWEEP and held through DONE -> first sweep unaffected; second sweep starts on the edge after DONE.
REQ-038 WIDTH=3 fault-free -> done 66 cycles after start, mismatch_count=0, a=b=3'b111 held afterwards.

Source files
------------

// File: rtl/demorgan_sweep.sv
// Exhaustive De Morgan self-check: walks every (a,b) pair, registers both law forms, counts mismatches.
// Results 1 cycle after each vector; no backpressure. Optional DEMORGAN_FAULT_INJECT_EN adds fault_mask.
module demorgan_sweep #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef DEMORGAN_FAULT_INJECT_EN
  input  logic [WIDTH-1:0]   fault_mask,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   nAandB,
  output logic [WIDTH-1:0]   nAorB,
  output logic [WIDTH-1:0]   nAornB,
  output logic [WIDTH-1:0]   nAandnB,
  output logic [2*WIDTH:0]   mismatch_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_INDEX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   index;
  logic            s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] nornb_d;
  logic            vec_fail;

  assign a = index[IW-1:WIDTH];
  assign b = index[WIDTH-1:0];

`ifdef DEMORGAN_FAULT_INJECT_EN
  assign nornb_d = ((~a) | (~b)) ^ fault_mask;
`else
  assign nornb_d = (~a) | (~b);
`endif

  // Stage 2: both law pairs must agree bit-for-bit for the vector held in stage 1.
  assign vec_fail = (nAornB != nAandB) || (nAandnB != nAorB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (index == LAST_INDEX) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index          <= '0;
      s1_vld         <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      nAandB         <= '0;
      nAorB          <= '0;
      nAornB         <= '0;
      nAandnB        <= '0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_a         <= '0;
      fail_b         <= '0;
    end else begin
      if (state == IDLE && start) begin
        index          <= '0;
        mismatch_count <= '0;
        fail_valid     <= 1'b0;
        fail_a         <= '0;
        fail_b         <= '0;
      end else begin
        // The last vector stays applied so a/b read back the final operands afterwards.
        if (state == SWEEP && index != LAST_INDEX) begin
          index <= index + 1'b1;
        end
        if (s1_vld && vec_fail) begin
          mismatch_count <= mismatch_count + 1'b1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= s1_a;
            fail_b     <= s1_b;
          end
        end
      end

      // Stage 1 only tracks vectors actually applied during the sweep.
      s1_vld <= (state == SWEEP);
      if (state == SWEEP) begin
        s1_a    <= a;
        s1_b    <= b;
        nAandB  <= ~(a & b);
        nAorB   <= ~(a | b);
        nAornB  <= nornb_d;
        nAandnB <= (~a) & (~b);
      end
    end
  end

endmodule

// File: tb/tb_demorgan_sweep.sv
// Randomised start/reset traffic on WIDTH=1,2,3 sweepers, checked through a cycle-tagged scoreboard.
module tb_demorgan_sweep;

  localparam int NCYC = 3000;
  localparam int TAIL = 100;

  typedef struct {
    int cyc;
    int inst;
    int kind;
    int val;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [1:3];
  logic st_v  [1:3];
  logic [11:0][7:0] obs [1:3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  rec_t sb[$];

  int idle_from [1:3];
  int hold_a [1:3];
  int hold_b [1:3];
  int hold_mc [1:3];
  int hold_fv [1:3];
  int hold_fa [1:3];
  int hold_fb [1:3];
  int hold_cnt [1:3];

  int e_nxt;
  logic r_d;
  logic s_d;
  int mon_act;

  // Kind index k selects byte k of obs: a,b,nAandB,nAorB,nAornB,nAandnB,done,busy,mcnt,fvld,fa,fb.
  for (genvar g = 1; g <= 3; g++) begin : gi
    localparam logic [g-1:0] FMV = (g == 2) ? 1 : ((g == 3) ? 4 : 0);
    logic busy, done, fv;
    logic [g-1:0] a, b, nand_o, nor_o, nornb_o, nandnb_o, fa, fb;
    logic [2*g:0] mc;

    demorgan_sweep #(.WIDTH(g)) dut (
      .clk            (clk),
      .reset          (rst_v[g]),
      .start          (st_v[g]),
`ifdef DEMORGAN_FAULT_INJECT_EN
      .fault_mask     (FMV),
`endif
      .busy           (busy),
      .done           (done),
      .a              (a),
      .b              (b),
      .nAandB         (nand_o),
      .nAorB          (nor_o),
      .nAornB         (nornb_o),
      .nAandnB        (nandnb_o),
      .mismatch_count (mc),
      .fail_valid     (fv),
      .fail_a         (fa),
      .fail_b         (fb)
    );

    assign obs[g] = {8'(fb), 8'(fa), 8'(fv), 8'(mc), 8'(busy), 8'(done),
                     8'(nandnb_o), 8'(nornb_o), 8'(nor_o), 8'(nand_o), 8'(b), 8'(a)};
  end

  function automatic int fmask(int inst);
`ifdef DEMORGAN_FAULT_INJECT_EN
    return (inst == 2) ? 1 : ((inst == 3) ? 4 : 0);
`else
    return 0;
`endif
  endfunction

  function automatic string kname(int k);
    case (k)
      0: return "a";
      1: return "b";
      2: return "nAandB";
      3: return "nAorB";
      4: return "nAornB";
      5: return "nAandnB";
      6: return "done";
      7: return "busy";
      8: return "mismatch_count";
      9: return "fail_valid";
      10: return "fail_a";
      default: return "fail_b";
    endcase
  endfunction

  function automatic void push(int c, int inst, int kind, int val);
    rec_t r;
    r.cyc = c;
    r.inst = inst;
    r.kind = kind;
    r.val = val;
    sb.push_back(r);
  endfunction

  // Idle cycle: results and operands hold, nothing in flight.
  function automatic void push_hold(int inst, int c);
    push(c, inst, 0, hold_a[inst]);
    push(c, inst, 1, hold_b[inst]);
    push(c, inst, 6, 0);
    push(c, inst, 7, 0);
    push(c, inst, 8, hold_mc[inst]);
    push(c, inst, 9, hold_fv[inst]);
    push(c, inst, 10, hold_fa[inst]);
    push(c, inst, 11, hold_fb[inst]);
  endfunction

  // Whole sweep predicted from the start edge k: vector i is applied in cycle k+i,
  // its law results appear in cycle k+i+1, and it is counted from cycle k+i+2.
  function automatic void push_sweep(int inst, int k);
    int n, m, fm, va, vb, nd, nr, onb, anb;
    int fails, fv, fa, fb;
    n = 1 << (2 * inst);
    m = (1 << inst) - 1;
    fm = fmask(inst);
    fails = 0; fv = 0; fa = 0; fb = 0;
    for (int j = 0; j <= n + 1; j++) begin
      if (j >= 2) begin
        va = (j - 2) >> inst;
        vb = (j - 2) & m;
        nd = m & ~(va & vb);
        nr = m & ~(va | vb);
        onb = (m & (~va | ~vb)) ^ fm;
        anb = m & (~va & ~vb);
        if (onb != nd || anb != nr) begin
          fails++;
          if (fv == 0) begin
            fv = 1; fa = va; fb = vb;
          end
        end
      end
      push(k + j, inst, 8, fails);
      push(k + j, inst, 9, fv);
      push(k + j, inst, 10, fa);
      push(k + j, inst, 11, fb);
    end
    for (int i = 0; i < n; i++) begin
      va = i >> inst;
      vb = i & m;
      push(k + i, inst, 0, va);
      push(k + i, inst, 1, vb);
      push(k + i, inst, 6, 0);
      push(k + i, inst, 7, 1);
      push(k + i + 1, inst, 2, m & ~(va & vb));
      push(k + i + 1, inst, 3, m & ~(va | vb));
      push(k + i + 1, inst, 4, (m & (~va | ~vb)) ^ fm);
      push(k + i + 1, inst, 5, m & (~va & ~vb));
    end
    push(k + n, inst, 0, m);
    push(k + n, inst, 1, m);
    push(k + n, inst, 6, 0);
    push(k + n, inst, 7, 1);
    push(k + n + 1, inst, 0, m);
    push(k + n + 1, inst, 1, m);
    push(k + n + 1, inst, 6, 1);
    push(k + n + 1, inst, 7, 0);
    hold_a[inst] = m; hold_b[inst] = m;
    hold_mc[inst] = fails; hold_fv[inst] = fv;
    hold_fa[inst] = fa; hold_fb[inst] = fb;
    push_hold(inst, k + n + 2);
    idle_from[inst] = k + n + 3;
  endfunction

  function automatic void model_edge(int inst, int e, logic rst, logic st);
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].inst == inst && sb[i].cyc >= e) sb.delete(i);
      end
      for (int k = 0; k < 12; k++) push(e, inst, k, 0);
      hold_a[inst] = 0; hold_b[inst] = 0; hold_mc[inst] = 0;
      hold_fv[inst] = 0; hold_fa[inst] = 0; hold_fb[inst] = 0;
      idle_from[inst] = e + 1;
    end else if (e >= idle_from[inst]) begin
      if (st) push_sweep(inst, e);
      else push_hold(inst, e);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        mon_act = int'(obs[sb[i].inst][sb[i].kind]);
        checks++;
        if (mon_act != sb[i].val) begin
          errors++;
          $display("FAIL %s W=%0d cycle %0d: got %0d expected %0d",
                   kname(sb[i].kind), sb[i].inst, cyc, mon_act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_%s W=%0d cycle %0d: got no sample expected %0d",
                 kname(sb[i].kind), sb[i].inst, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    for (int g = 1; g <= 3; g++) begin
      rst_v[g] = 1'b1;
      st_v[g] = 1'b0;
      idle_from[g] = 0;
      hold_cnt[g] = 0;
      hold_a[g] = 0; hold_b[g] = 0; hold_mc[g] = 0;
      hold_fv[g] = 0; hold_fa[g] = 0; hold_fb[g] = 0;
    end
    for (int t = 0; t < NCYC + TAIL; t++) begin
      e_nxt = cyc + 1;
      for (int g = 1; g <= 3; g++) begin
        if (t < 3) r_d = 1'b1;
        else if (t >= NCYC) r_d = 1'b0;
        else r_d = ($urandom_range(0, (g == 2) ? 70 : ((g == 3) ? 500 : 120)) == 0);
        if (t >= NCYC) begin
          s_d = 1'b0;
        end else if (hold_cnt[g] > 0) begin
          s_d = 1'b1;
          hold_cnt[g]--;
        end else if ($urandom_range(0, 5) == 0) begin
          s_d = 1'b1;
          if ($urandom_range(0, 3) == 0) hold_cnt[g] = $urandom_range(5, 90);
        end else begin
          s_d = 1'b0;
        end
        rst_v[g] = r_d;
        st_v[g] = s_d;
        model_edge(g, e_nxt, r_d, s_d);
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
